i2c_target_core: RTL and testbench

I2C target (responder) byte engine: the other end of the bus from the master-side TX/RX FIFO data path. It oversamples the open-drain SCL/SDA lines on the I2C core clock and detects START and STOP. It matches a 7-bit address, ACKs or NACKs, and exchanges bytes with a local byte-stream interface. It serves as the on-chip responder for loopback and for bench self-checks of the master path. It does no clock stretching.

---
 rtl/i2c_target_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_i2c_target_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_core.sv
// I2C target byte engine: oversampled START/STOP detection, 7-bit address match,
// byte-stream write sink and read source. No clock stretching.
module i2c_target_core #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       i2c_core_clk_i,
  input  logic       i2c_core_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_full_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       underrun_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       addressed_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  // Synchronisers reset to the idle (released) bus level so reset never fakes an edge.
  logic scl_meta, scl_sync, scl_hist;
  logic sda_meta, sda_sync, sda_hist;

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  // SCL must be stable high across both samples, so a simultaneous SCL/SDA change is data.
  assign scl_rise  = scl_sync & ~scl_hist;
  assign scl_fall  = ~scl_sync & scl_hist;
  assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
  assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [1:0] phase_reg, phase_next;
  logic       rw_reg, rw_next;
  logic       ack_reg, ack_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       addressed_reg, addressed_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_ready_reg, tx_ready_next;
  logic       underrun_reg, underrun_next;
  logic       start_reg, start_next;
  logic       stop_reg, stop_next;

  logic [7:0] shift_in, load_byte;
  assign shift_in  = {shift_reg[6:0], sda_sync};
  assign load_byte = tx_valid_i ? tx_data_i : 8'hFF;

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      phase_reg     <= 2'd0;
      rw_reg        <= 1'b0;
      ack_reg       <= 1'b0;
      sda_oe_reg    <= 1'b0;
      addressed_reg <= 1'b0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      tx_ready_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      start_reg     <= 1'b0;
      stop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      phase_reg     <= phase_next;
      rw_reg        <= rw_next;
      ack_reg       <= ack_next;
      sda_oe_reg    <= sda_oe_next;
      addressed_reg <= addressed_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      tx_ready_reg  <= tx_ready_next;
      underrun_reg  <= underrun_next;
      start_reg     <= start_next;
      stop_reg      <= stop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    phase_next     = phase_reg;
    rw_next        = rw_reg;
    ack_next       = ack_reg;
    sda_oe_next    = sda_oe_reg;
    addressed_next = addressed_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    tx_ready_next  = 1'b0;
    underrun_next  = 1'b0;
    start_next     = 1'b0;
    stop_next      = 1'b0;

    if (start_det) begin
      state_next     = ADDR;
      bit_cnt_next   = 3'd0;
      sda_oe_next    = 1'b0;
      addressed_next = 1'b0;
      start_next     = 1'b1;
    end else if (stop_det) begin
      state_next     = IDLE;
      sda_oe_next    = 1'b0;
      addressed_next = 1'b0;
      stop_next      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          sda_oe_next = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_next   = shift_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (shift_reg[6:0] == TARGET_ADDR) begin
                state_next = ADDR_ACK;
                rw_next    = sda_sync;
                phase_next = 2'd0;
              end else begin
                state_next = WAIT_STOP;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (phase_reg == 2'd0) begin
              sda_oe_next    = 1'b1;
              addressed_next = 1'b1;
              phase_next     = 2'd1;
            end else begin
              bit_cnt_next = 3'd0;
              if (rw_reg) begin
                // First read bit must be on the line by the end of this SCL low phase.
                shift_next    = load_byte;
                sda_oe_next   = ~load_byte[7];
                tx_ready_next = tx_valid_i;
                underrun_next = ~tx_valid_i;
                state_next    = RD_DATA;
              end else begin
                sda_oe_next = 1'b0;
                state_next  = WR_DATA;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_next   = shift_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (!rx_full_i) begin
                rx_data_next  = shift_in;
                rx_valid_next = 1'b1;
                ack_next      = 1'b1;
              end else begin
                ack_next = 1'b0;
              end
              state_next = WR_ACK;
              phase_next = 2'd0;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (phase_reg == 2'd0) begin
              sda_oe_next = ack_reg;
              phase_next  = 2'd1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 3'd0;
              if (ack_reg) begin
                state_next = WR_DATA;
              end else begin
                addressed_next = 1'b0;
                state_next     = WAIT_STOP;
              end
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            shift_next   = {shift_reg[6:0], 1'b1};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next = RD_ACK;
              phase_next = 2'd0;
            end
          end else if (scl_fall) begin
            sda_oe_next = ~shift_reg[7];
          end
        end

        RD_ACK: begin
          // Phases: release SDA, sample master ACK, then load the next byte.
          if (phase_reg == 2'd0) begin
            if (scl_fall) begin
              sda_oe_next = 1'b0;
              phase_next  = 2'd1;
            end
          end else if (phase_reg == 2'd1) begin
            if (scl_rise) begin
              if (!sda_sync) begin
                phase_next = 2'd2;
              end else begin
                addressed_next = 1'b0;
                state_next     = WAIT_STOP;
              end
            end
          end else begin
            if (scl_fall) begin
              shift_next    = load_byte;
              sda_oe_next   = ~load_byte[7];
              tx_ready_next = tx_valid_i;
              underrun_next = ~tx_valid_i;
              bit_cnt_next  = 3'd0;
              state_next    = RD_DATA;
            end
          end
        end

        WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end

        default: begin
          state_next  = IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o    = sda_oe_reg;
  assign rx_data_o   = rx_data_reg;
  assign rx_valid_o  = rx_valid_reg;
  assign tx_ready_o  = tx_ready_reg;
  assign underrun_o  = underrun_reg;
  assign start_o     = start_reg;
  assign stop_o      = stop_reg;
  assign addressed_o = addressed_reg;

endmodule

// File: tb/tb_i2c_target_core.sv
// Bench for i2c_target_core: bit-level I2C master, transaction-level model feeding
// an event scoreboard, and a monitor that pops expected events as the DUT pulses.
module tb_i2c_target_core;

  localparam int Q = 100;  // quarter SCL period in time units (10 core clocks)
  localparam int K_START = 1, K_STOP = 2, K_RX = 3, K_TXR = 4, K_UND = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, underrun, start_p, stop_p, addressed;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_core #(.TARGET_ADDR(7'h50)) dut (
    .i2c_core_clk_i(clk),
    .i2c_core_rst_i(rst),
    .scl_i(scl),
    .sda_i(sda_line),
    .sda_oe_o(sda_oe),
    .rx_data_o(rx_data),
    .rx_valid_o(rx_valid),
    .rx_full_i(rx_full),
    .tx_data_i(tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .underrun_o(underrun),
    .start_o(start_p),
    .stop_o(stop_p),
    .addressed_o(addressed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int oe_cnt = 0;
  int txn_no = 0;
  bit in_bus = 1'b0;

  bit [7:0] t_data[8];
  bit       t_full[8];
  bit       t_tvalid[8];
  int       t_n;

  function automatic int ev(int kind, int data);
    return kind * 256 + data;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input int obs);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind %0d data %02h, none expected",
               name, obs / 256, obs % 256);
    end else begin
      e = exp_q.pop_front();
      if (e != obs) begin
        errors++;
        $display("FAIL %s: got kind %0d data %02h, expected kind %0d data %02h",
                 name, obs / 256, obs % 256, e / 256, e % 256);
      end
    end
  endtask

  // Monitor: consumes DUT pulses independently of the stimulus thread.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_cnt++;
      if (start_p)  sb_pop("start_ev", ev(K_START, 0));
      if (rx_valid) sb_pop("rx_ev", ev(K_RX, int'(rx_data)));
      if (tx_ready) sb_pop("tx_ready_ev", ev(K_TXR, int'(tx_data)));
      if (underrun) sb_pop("underrun_ev", ev(K_UND, 8'hFF));
      if (stop_p)   sb_pop("stop_ev", ev(K_STOP, 0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 2_000_000);
    $fatal(1, "watchdog");
  end

  task automatic clk_bit(input bit b, output bit s);
    m_sda = b;
    #Q scl = 1'b1;
    #Q s = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic gen_start();
    if (in_bus) begin
      m_sda = 1'b1;
      #Q scl = 1'b1;
      #Q m_sda = 1'b0;
      #Q scl = 1'b0;
      #Q;
    end else begin
      m_sda = 1'b0;
      #(2 * Q) scl = 1'b0;
      #Q;
    end
    in_bus = 1'b1;
  endtask

  task automatic gen_stop();
    m_sda = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda = 1'b1;
    #(2 * Q);
    in_bus = 1'b0;
  endtask

  task automatic set_tx(input int k);
    tx_data  = t_data[k];
    tx_valid = t_tvalid[k];
  endtask

  // One master transaction; expected bus responses come from the I2C rules, not the RTL.
  task automatic run_txn(input bit [7:0] addr_byte, input bit sr_end);
    bit match, rw, alive, s, last;
    bit [7:0] got, exp_b;
    match = (addr_byte[7:1] == 7'h50);
    rw    = addr_byte[0];

    exp_q.push_back(ev(K_START, 0));
    if (match && !rw) begin
      alive = 1'b1;
      for (int k = 0; k < t_n; k++) begin
        if (alive && !t_full[k]) exp_q.push_back(ev(K_RX, int'(t_data[k])));
        if (t_full[k]) alive = 1'b0;
      end
    end
    if (match && rw) begin
      for (int k = 0; k < t_n; k++)
        exp_q.push_back(t_tvalid[k] ? ev(K_TXR, int'(t_data[k])) : ev(K_UND, 8'hFF));
    end
    if (!sr_end) exp_q.push_back(ev(K_STOP, 0));

    oe_cnt = 0;
    gen_start();
    for (int i = 7; i >= 0; i--) clk_bit(addr_byte[i], s);
    if (match && rw) set_tx(0);
    clk_bit(1'b1, s);
    chk("addr_ack", int'(s), int'(!match));
    chk("addressed_at_ack", int'(addressed), int'(match));

    if (!rw) begin
      alive = match;
      for (int k = 0; k < t_n; k++) begin
        rx_full = t_full[k];
        for (int i = 7; i >= 0; i--) clk_bit(t_data[k][i], s);
        rx_full = 1'b0;
        clk_bit(1'b1, s);
        chk("wr_ack", int'(s), int'(!(alive && !t_full[k])));
        if (t_full[k]) alive = 1'b0;
      end
    end else if (match) begin
      for (int k = 0; k < t_n; k++) begin
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
          clk_bit(1'b1, s);
          got = {got[6:0], s};
        end
        exp_b = t_tvalid[k] ? t_data[k] : 8'hFF;
        chk("rd_byte", int'(got), int'(exp_b));
        last = (k == t_n - 1);
        if (!last) set_tx(k + 1);
        clk_bit(last, s);
      end
      chk("rd_release", int'(sda_oe), 0);
    end
    tx_valid = 1'b0;

    if (!sr_end) begin
      gen_stop();
      chk("addressed_after_stop", int'(addressed), 0);
    end
    if (!match) chk("mismatch_sda_untouched", oe_cnt, 0);
    $display("txn %0d addr=%02h rw=%0d n=%0d sr=%0d", txn_no, addr_byte, rw, t_n, sr_end);
    txn_no++;
  endtask

  task automatic reset_mid_ack();
    bit s;
    exp_q.push_back(ev(K_START, 0));
    exp_q.push_back(ev(K_RX, 8'h77));
    exp_q.push_back(ev(K_STOP, 0));
    gen_start();
    for (int i = 7; i >= 0; i--) clk_bit(1'(8'hA0 >> i), s);
    clk_bit(1'b1, s);
    chk("rst_addr_ack", int'(s), 0);
    for (int i = 7; i >= 0; i--) clk_bit(1'(8'h77 >> i), s);
    m_sda = 1'b1;
    #Q scl = 1'b1;
    #(Q / 2);
    chk("rst_ack_driven", int'(sda_oe), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_oe", int'(sda_oe), 0);
    chk("rst_addressed", int'(addressed), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    #(Q / 2 - 1) rst = 1'b0;
    #Q scl = 1'b0;
    #Q;
    gen_stop();
    $display("txn %0d reset during ACK drive", txn_no);
    txn_no++;
  endtask

  initial begin
    bit [7:0] a;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #20;
    chk("reset_sda_oe", int'(sda_oe), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_pulses", int'({rx_valid, tx_ready, underrun, start_p, stop_p}), 0);
    chk("reset_addressed", int'(addressed), 0);

    t_n = 2; t_data[0] = 8'h3C; t_data[1] = 8'hC3; t_full[0] = 0; t_full[1] = 0;
    run_txn(8'hA0, 1'b0);

    t_n = 1; t_data[0] = 8'h55; t_full[0] = 0;
    run_txn(8'hA2, 1'b0);

    t_n = 2; t_data[0] = 8'h5A; t_data[1] = 8'h96; t_tvalid[0] = 1; t_tvalid[1] = 1;
    run_txn(8'hA1, 1'b0);

    t_n = 1; t_data[0] = 8'h42; t_tvalid[0] = 0;
    run_txn(8'hA1, 1'b0);

    t_n = 3; t_data[0] = 8'h11; t_data[1] = 8'h22; t_data[2] = 8'h33;
    t_full[0] = 0; t_full[1] = 1; t_full[2] = 0;
    run_txn(8'hA0, 1'b0);

    t_n = 1; t_data[0] = 8'h01; t_full[0] = 0;
    run_txn(8'hA0, 1'b1);
    t_n = 1; t_data[0] = 8'hE7; t_tvalid[0] = 1;
    run_txn(8'hA1, 1'b0);

    reset_mid_ack();
    t_n = 2; t_data[0] = 8'h9D; t_data[1] = 8'h00; t_full[0] = 0; t_full[1] = 0;
    run_txn(8'hA0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      a[7:1] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      a[0]   = 1'($urandom);
      t_n    = $urandom_range(1, 3);
      for (int k = 0; k < t_n; k++) begin
        t_data[k]   = 8'($urandom);
        t_full[k]   = ($urandom_range(0, 4) == 0);
        t_tvalid[k] = ($urandom_range(0, 4) != 0);
      end
      run_txn(a, (r != 15) && ($urandom_range(0, 3) == 0));
    end

    #(4 * Q);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
